// File: rtl/round_ctrl.sv
// rtl/round_ctrl.sv - game-round sequencer driving the countdown timer and keeping score
module round_ctrl #(
    parameter int NUM_ROUNDS = 5,
    parameter int SCORE_W    = 8,
    parameter int PTS_HARD   = 2,
    parameter int PTS_EASY   = 1,
    parameter int SCORE_HOLD = 4
) (
    input  logic               Clk,
    input  logic               Rst,
    input  logic               Start,
    input  logic               ModeSel,
    input  logic               GuessValid,
    input  logic               GuessCorrect,
    input  logic               Timeout,
    output logic               TimerEnable,
    output logic               EnableScore,
    output logic               ChildMode,
    output logic [SCORE_W-1:0] Score,
    output logic [3:0]         RoundNum,
    output logic               RoundWon,
    output logic               RoundLost,
    output logic               GameOver
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ARM   = 3'd1,
        S_PLAY  = 3'd2,
        S_SCORE = 3'd3,
        S_OVER  = 3'd4
    } state_t;

    localparam int HW = (SCORE_HOLD > 1) ? $clog2(SCORE_HOLD) : 1;
    localparam logic [HW-1:0]    HOLD_LAST  = HW'(SCORE_HOLD - 1);
    localparam logic [3:0]       LAST_ROUND = 4'(NUM_ROUNDS);
    localparam logic [SCORE_W:0] PTS_H      = (SCORE_W + 1)'(PTS_HARD);
    localparam logic [SCORE_W:0] PTS_E      = (SCORE_W + 1)'(PTS_EASY);

    state_t              state, state_nxt;
    logic [HW-1:0]       hold_cnt, hold_nxt;
    logic                te_nxt, es_nxt, child_nxt, won_nxt, lost_nxt, over_nxt;
    logic [SCORE_W-1:0]  score_nxt;
    logic [3:0]          round_nxt;
    logic [SCORE_W:0]    score_sum;
    logic [SCORE_W-1:0]  score_sat;

    // Score plus this round's points, one bit wider so an overflow clamps instead of wrapping
    always_comb begin
        score_sum = {1'b0, Score} + (ChildMode ? PTS_E : PTS_H);
        score_sat = score_sum[SCORE_W] ? {SCORE_W{1'b1}} : score_sum[SCORE_W-1:0];
    end

    // State register and registered outputs; reset clears everything without a clock
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state       <= S_IDLE;
            hold_cnt    <= '0;
            TimerEnable <= 1'b0;
            EnableScore <= 1'b0;
            ChildMode   <= 1'b0;
            Score       <= '0;
            RoundNum    <= 4'd0;
            RoundWon    <= 1'b0;
            RoundLost   <= 1'b0;
            GameOver    <= 1'b0;
        end else begin
            state       <= state_nxt;
            hold_cnt    <= hold_nxt;
            TimerEnable <= te_nxt;
            EnableScore <= es_nxt;
            ChildMode   <= child_nxt;
            Score       <= score_nxt;
            RoundNum    <= round_nxt;
            RoundWon    <= won_nxt;
            RoundLost   <= lost_nxt;
            GameOver    <= over_nxt;
        end
    end

    // Next state and next output values; pulses default low, levels default to hold
    always_comb begin
        state_nxt = state;
        hold_nxt  = hold_cnt;
        te_nxt    = 1'b0;
        won_nxt   = 1'b0;
        lost_nxt  = 1'b0;
        es_nxt    = EnableScore;
        child_nxt = ChildMode;
        score_nxt = Score;
        round_nxt = RoundNum;
        over_nxt  = GameOver;
        case (state)
            S_IDLE, S_OVER: begin
                if (Start) begin
                    state_nxt = S_ARM;
                    te_nxt    = 1'b1;
                    es_nxt    = 1'b0;
                    over_nxt  = 1'b0;
                    child_nxt = ModeSel;
                    score_nxt = '0;
                    round_nxt = 4'd1;
                end
            end
            // Timer is being loaded this cycle, so a stale Timeout is not trusted
            S_ARM: begin
                state_nxt = S_PLAY;
                es_nxt    = 1'b0;
            end
            S_PLAY: begin
                if (GuessValid && GuessCorrect) begin
                    state_nxt = S_SCORE;
                    score_nxt = score_sat;
                    won_nxt   = 1'b1;
                    es_nxt    = 1'b1;
                    hold_nxt  = '0;
                end else if (Timeout) begin
                    state_nxt = S_SCORE;
                    lost_nxt  = 1'b1;
                    es_nxt    = 1'b1;
                    hold_nxt  = '0;
                end
            end
            S_SCORE: begin
                if (hold_cnt == HOLD_LAST) begin
                    if (RoundNum == LAST_ROUND) begin
                        state_nxt = S_OVER;
                        over_nxt  = 1'b1;
                    end else begin
                        state_nxt = S_ARM;
                        round_nxt = RoundNum + 4'd1;
                        te_nxt    = 1'b1;
                        es_nxt    = 1'b0;
                    end
                end else begin
                    hold_nxt = hold_cnt + 1'b1;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_round_ctrl.sv
// tb/tb_round_ctrl.sv - directed self-checking bench for round_ctrl
module tb_round_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0, mode_sel = 1'b0, guess_valid = 1'b0, guess_correct = 1'b0, timeout = 1'b0;
    logic       timer_enable, enable_score, child_mode, round_won, round_lost, game_over;
    logic [7:0] score;
    logic [3:0] round_num;

    logic       b_start = 1'b0, b_mode_sel = 1'b0, b_guess_valid = 1'b0, b_guess_correct = 1'b0, b_timeout = 1'b0;
    logic       b_timer_enable, b_enable_score, b_child_mode, b_round_won, b_round_lost, b_game_over;
    logic [1:0] b_score;
    logic [3:0] b_round_num;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    round_ctrl #(.NUM_ROUNDS(3), .SCORE_W(8), .PTS_HARD(2), .PTS_EASY(1), .SCORE_HOLD(4)) dut (
        .Clk(clk), .Rst(rst), .Start(start), .ModeSel(mode_sel), .GuessValid(guess_valid),
        .GuessCorrect(guess_correct), .Timeout(timeout), .TimerEnable(timer_enable),
        .EnableScore(enable_score), .ChildMode(child_mode), .Score(score), .RoundNum(round_num),
        .RoundWon(round_won), .RoundLost(round_lost), .GameOver(game_over)
    );

    round_ctrl #(.NUM_ROUNDS(5), .SCORE_W(2), .PTS_HARD(2), .PTS_EASY(1), .SCORE_HOLD(4)) dut_sat (
        .Clk(clk), .Rst(rst), .Start(b_start), .ModeSel(b_mode_sel), .GuessValid(b_guess_valid),
        .GuessCorrect(b_guess_correct), .Timeout(b_timeout), .TimerEnable(b_timer_enable),
        .EnableScore(b_enable_score), .ChildMode(b_child_mode), .Score(b_score), .RoundNum(b_round_num),
        .RoundWon(b_round_won), .RoundLost(b_round_lost), .GameOver(b_game_over)
    );

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick(2);
        checks++;
        if ({timer_enable, enable_score, child_mode, round_won, round_lost, game_over} !== 6'b0 ||
            score !== 8'd0 || round_num !== 4'd0) begin
            failures++;
            $display("FAIL reset_outputs: te=%b es=%b cm=%b won=%b lost=%b go=%b score=%0d round=%0d, want all 0",
                     timer_enable, enable_score, child_mode, round_won, round_lost, game_over, score, round_num);
        end
        rst = 1'b0;
        tick(2);
        checks++;
        if (timer_enable !== 1'b0 || round_num !== 4'd0) begin
            failures++;
            $display("FAIL idle_quiet: te=%b round=%0d, want 0 0", timer_enable, round_num);
        end
    endtask

    task automatic test_first_round;
        start = 1'b1; mode_sel = 1'b0;
        tick();
        start = 1'b0;
        checks++;
        if (timer_enable !== 1'b1 || round_num !== 4'd1 || score !== 8'd0 || child_mode !== 1'b0) begin
            failures++;
            $display("FAIL arm_after_start: te=%b round=%0d score=%0d cm=%b, want 1 1 0 0",
                     timer_enable, round_num, score, child_mode);
        end
        tick();
        checks++;
        if (timer_enable !== 1'b0 || enable_score !== 1'b0) begin
            failures++;
            $display("FAIL play_entry: te=%b es=%b, want 0 0", timer_enable, enable_score);
        end
        guess_valid = 1'b1; guess_correct = 1'b1;
        tick();
        guess_valid = 1'b0; guess_correct = 1'b0;
        checks++;
        if (round_won !== 1'b1 || round_lost !== 1'b0 || score !== 8'd2) begin
            failures++;
            $display("FAIL first_win: won=%b lost=%b score=%0d, want 1 0 2", round_won, round_lost, score);
        end
        for (int c = 1; c <= 4; c++) begin
            checks++;
            if (enable_score !== 1'b1 || timer_enable !== 1'b0 || (c > 1 && round_won !== 1'b0)) begin
                failures++;
                $display("FAIL score_hold_cycle%0d: es=%b te=%b won=%b, want 1 0 %b",
                         c, enable_score, timer_enable, round_won, (c == 1));
            end
            tick();
        end
        checks++;
        if (enable_score !== 1'b0 || timer_enable !== 1'b1 || round_num !== 4'd2) begin
            failures++;
            $display("FAIL rearm_round2: es=%b te=%b round=%0d, want 0 1 2", enable_score, timer_enable, round_num);
        end
    endtask

    task automatic test_timeout;
        timeout = 1'b1;
        tick();
        timeout = 1'b0;
        checks++;
        if (round_lost !== 1'b0 || timer_enable !== 1'b0 || enable_score !== 1'b0) begin
            failures++;
            $display("FAIL stale_timeout_in_arm: lost=%b te=%b es=%b, want 0 0 0", round_lost, timer_enable, enable_score);
        end
        guess_valid = 1'b1; guess_correct = 1'b0;
        tick();
        guess_valid = 1'b0;
        checks++;
        if (round_won !== 1'b0 || round_lost !== 1'b0 || score !== 8'd2 || enable_score !== 1'b0) begin
            failures++;
            $display("FAIL wrong_guess: won=%b lost=%b score=%0d es=%b, want 0 0 2 0",
                     round_won, round_lost, score, enable_score);
        end
        timeout = 1'b1;
        tick();
        timeout = 1'b0;
        checks++;
        if (round_lost !== 1'b1 || round_won !== 1'b0 || score !== 8'd2 || enable_score !== 1'b1) begin
            failures++;
            $display("FAIL timeout_loss: lost=%b won=%b score=%0d es=%b, want 1 0 2 1",
                     round_lost, round_won, score, enable_score);
        end
        tick();
        checks++;
        if (round_lost !== 1'b0) begin
            failures++;
            $display("FAIL lost_one_cycle: lost=%b, want 0", round_lost);
        end
        tick(3);
        checks++;
        if (timer_enable !== 1'b1 || round_num !== 4'd3) begin
            failures++;
            $display("FAIL rearm_round3: te=%b round=%0d, want 1 3", timer_enable, round_num);
        end
    endtask

    task automatic test_win_and_timeout;
        tick();
        guess_valid = 1'b1; guess_correct = 1'b1; timeout = 1'b1;
        tick();
        guess_valid = 1'b0; guess_correct = 1'b0; timeout = 1'b0;
        checks++;
        if (round_won !== 1'b1 || round_lost !== 1'b0 || score !== 8'd4) begin
            failures++;
            $display("FAIL win_beats_timeout: won=%b lost=%b score=%0d, want 1 0 4", round_won, round_lost, score);
        end
        guess_valid = 1'b1; guess_correct = 1'b1;
        tick();
        guess_valid = 1'b0; guess_correct = 1'b0;
        checks++;
        if (score !== 8'd4 || round_won !== 1'b0) begin
            failures++;
            $display("FAIL guess_in_score_ignored: score=%0d won=%b, want 4 0", score, round_won);
        end
        tick(3);
        checks++;
        if (game_over !== 1'b1 || enable_score !== 1'b1 || timer_enable !== 1'b0 ||
            score !== 8'd4 || round_num !== 4'd3) begin
            failures++;
            $display("FAIL game_over: go=%b es=%b te=%b score=%0d round=%0d, want 1 1 0 4 3",
                     game_over, enable_score, timer_enable, score, round_num);
        end
        tick(2);
        checks++;
        if (game_over !== 1'b1 || score !== 8'd4) begin
            failures++;
            $display("FAIL game_over_held: go=%b score=%0d, want 1 4", game_over, score);
        end
    endtask

    task automatic test_restart;
        start = 1'b1; mode_sel = 1'b1;
        tick();
        start = 1'b0; mode_sel = 1'b0;
        checks++;
        if (game_over !== 1'b0 || score !== 8'd0 || round_num !== 4'd1 || child_mode !== 1'b1 ||
            timer_enable !== 1'b1 || enable_score !== 1'b0) begin
            failures++;
            $display("FAIL restart: go=%b score=%0d round=%0d cm=%b te=%b es=%b, want 0 0 1 1 1 0",
                     game_over, score, round_num, child_mode, timer_enable, enable_score);
        end
        tick();
        guess_valid = 1'b1; guess_correct = 1'b1;
        tick();
        guess_valid = 1'b0; guess_correct = 1'b0;
        checks++;
        if (score !== 8'd1 || round_won !== 1'b1 || child_mode !== 1'b1) begin
            failures++;
            $display("FAIL easy_win: score=%0d won=%b cm=%b, want 1 1 1", score, round_won, child_mode);
        end
        tick(4);
        tick();
    endtask

    task automatic test_reset_mid_play;
        rst = 1'b1;
        #1;
        checks++;
        if ({timer_enable, enable_score, child_mode, round_won, round_lost, game_over} !== 6'b0 ||
            score !== 8'd0 || round_num !== 4'd0) begin
            failures++;
            $display("FAIL async_reset: te=%b es=%b cm=%b won=%b lost=%b go=%b score=%0d round=%0d, want all 0",
                     timer_enable, enable_score, child_mode, round_won, round_lost, game_over, score, round_num);
        end
        tick();
        rst = 1'b0;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if (timer_enable !== 1'b1 || round_num !== 4'd1 || child_mode !== 1'b0) begin
            failures++;
            $display("FAIL start_after_reset: te=%b round=%0d cm=%b, want 1 1 0", timer_enable, round_num, child_mode);
        end
    endtask

    task automatic test_saturation;
        b_start = 1'b1;
        tick();
        b_start = 1'b0;
        tick();
        b_start = 1'b1;
        tick();
        b_start = 1'b0;
        checks++;
        if (b_timer_enable !== 1'b0 || b_round_num !== 4'd1 || b_enable_score !== 1'b0) begin
            failures++;
            $display("FAIL start_in_play_ignored: te=%b round=%0d es=%b, want 0 1 0",
                     b_timer_enable, b_round_num, b_enable_score);
        end
        b_guess_valid = 1'b1; b_guess_correct = 1'b1;
        tick();
        b_guess_valid = 1'b0; b_guess_correct = 1'b0;
        checks++;
        if (b_score !== 2'd2 || b_round_won !== 1'b1) begin
            failures++;
            $display("FAIL sat_first_win: score=%0d won=%b, want 2 1", b_score, b_round_won);
        end
        tick(4);
        tick();
        b_guess_valid = 1'b1; b_guess_correct = 1'b1;
        tick();
        b_guess_valid = 1'b0; b_guess_correct = 1'b0;
        checks++;
        if (b_score !== 2'd3 || b_round_won !== 1'b1 || b_round_num !== 4'd2) begin
            failures++;
            $display("FAIL saturate: score=%0d won=%b round=%0d, want 3 1 2", b_score, b_round_won, b_round_num);
        end
    endtask

    initial begin
        test_reset();
        test_first_round();
        test_timeout();
        test_win_and_timeout();
        test_restart();
        test_reset_mid_play();
        test_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
